// File: rtl/decode_stage_hs.sv
// decode_stage_hs: MIPS-subset decode stage with a register file, control decode,
// sign extension and jump-target generation. It uses a valid/ready handshake,
// write-through bypass, load-use stall detection, flush and a saturating stall counter.
`timescale 1ns/1ps
module decode_stage_hs #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int R1_INIT = 1,
   parameter bit BYPASS  = 1'b1,
   parameter int SCNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   pc,
   input  logic [31:0]       ir,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              ex_memread,
   input  logic [4:0]        ex_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              memtoreg,
   output logic              regwrite,
   output logic              memread,
   output logic              memwrite,
   output logic              branch,
   output logic              jump,
   output logic [2:0]        alu_ctr,
   output logic [XLEN-1:0]   a,
   output logic [XLEN-1:0]   b,
   output logic [XLEN-1:0]   md,
   output logic [15:0]       imm,
   output logic [4:0]        rd,
   output logic [XLEN-1:0]   npc,
   output logic [XLEN-1:0]   jt,
   output logic              illegal,
   output logic [SCNT_W-1:0] stall_cnt
);

   localparam int IW = $clog2(NREG);

   localparam logic [5:0] OP_R = 6'd0,  OP_J  = 6'd2,  OP_BEQ = 6'd4;
   localparam logic [5:0] OP_BNE = 6'd5, OP_LW = 6'd35, OP_SW  = 6'd43;
   localparam logic [5:0] FN_ADD = 6'd32, FN_SUB = 6'd34, FN_AND = 6'd36;
   localparam logic [5:0] FN_OR  = 6'd37, FN_SLT = 6'd42;

   function automatic logic signed [XLEN-1:0] sext16(input logic signed [15:0] v);
      return {{(XLEN-16){v[15]}}, v};
   endfunction

   function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [XLEN-1:0] regs [NREG];
   logic [5:0]      op_p0, fn_p0;
   logic [IW-1:0]   rs_idx, rt_idx, wb_idx;
   logic [XLEN-1:0] rs_val_p0, rt_val_p0, b_p0;
   logic [4:0]      rd_p0;
   logic [2:0]      alu_p0;
   logic            memtoreg_p0, regwrite_p0, memread_p0, memwrite_p0;
   logic            branch_p0, jump_p0, illegal_p0;
   logic            uses_rt, hazard, advance, accept;

   assign op_p0  = ir[31:26];
   assign fn_p0  = ir[5:0];
   assign rs_idx = ir[21 +: IW];
   assign rt_idx = ir[16 +: IW];
   assign wb_idx = wb_rd[IW-1:0];

   // Register file: r0 is never written, r1 has a configurable reset value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         regs[1] <= XLEN'(R1_INIT);
      end else if (wb_en && (wb_idx != '0)) begin
         regs[wb_idx] <= wb_data;
      end
   end

   // Register read with optional same-cycle writeback forwarding; r0 always reads 0
   always_comb begin
      rs_val_p0 = regs[rs_idx];
      rt_val_p0 = regs[rt_idx];
      if (BYPASS && wb_en && (wb_idx != '0)) begin
         if (rs_idx == wb_idx) rs_val_p0 = wb_data;
         if (rt_idx == wb_idx) rt_val_p0 = wb_data;
      end
      if (rs_idx == '0) rs_val_p0 = '0;
      if (rt_idx == '0) rt_val_p0 = '0;
   end

   // Load-use hazard: rt only matters for formats that actually read it
   assign uses_rt  = (op_p0 == OP_R) || (op_p0 == OP_SW) || (op_p0 == OP_BEQ) || (op_p0 == OP_BNE);
   assign hazard   = ex_memread && (ex_rd != 5'd0) &&
                     ((ex_rd == ir[25:21]) || (uses_rt && (ex_rd == ir[20:16])));
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   // Control decode; unsupported opcodes/functs raise illegal with all controls low
   always_comb begin
      memtoreg_p0 = 1'b0;
      regwrite_p0 = 1'b0;
      memread_p0  = 1'b0;
      memwrite_p0 = 1'b0;
      branch_p0   = 1'b0;
      jump_p0     = 1'b0;
      illegal_p0  = 1'b0;
      alu_p0      = 3'd0;
      b_p0        = rt_val_p0;
      rd_p0       = ir[20:16];
      case (op_p0)
         OP_R: begin
            rd_p0       = ir[15:11];
            regwrite_p0 = 1'b1;
            case (fn_p0)
               FN_ADD:  alu_p0 = 3'd0;
               FN_SUB:  alu_p0 = 3'd1;
               FN_AND:  alu_p0 = 3'd2;
               FN_OR:   alu_p0 = 3'd3;
               FN_SLT:  alu_p0 = 3'd4;
               default: begin
                  regwrite_p0 = 1'b0;
                  illegal_p0  = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            b_p0        = sext16(ir[15:0]);
            memtoreg_p0 = 1'b1;
            regwrite_p0 = 1'b1;
            memread_p0  = 1'b1;
         end
         OP_SW: begin
            b_p0        = sext16(ir[15:0]);
            memwrite_p0 = 1'b1;
         end
         OP_BEQ: begin
            branch_p0 = 1'b1;
            alu_p0    = 3'd5;
         end
         OP_BNE: begin
            branch_p0 = 1'b1;
            alu_p0    = 3'd6;
         end
         OP_J: begin
            jump_p0   = 1'b1;
            branch_p0 = 1'b1;
            alu_p0    = 3'd7;
         end
         default: illegal_p0 = 1'b1;
      endcase
   end

   // Output bundle register: flush > accept > bubble > hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         memtoreg  <= 1'b0;
         regwrite  <= 1'b0;
         memread   <= 1'b0;
         memwrite  <= 1'b0;
         branch    <= 1'b0;
         jump      <= 1'b0;
         illegal   <= 1'b0;
         alu_ctr   <= 3'd0;
         a         <= '0;
         b         <= '0;
         md        <= '0;
         imm       <= '0;
         rd        <= '0;
         npc       <= '0;
         jt        <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         memtoreg  <= memtoreg_p0;
         regwrite  <= regwrite_p0;
         memread   <= memread_p0;
         memwrite  <= memwrite_p0;
         branch    <= branch_p0;
         jump      <= jump_p0;
         illegal   <= illegal_p0;
         alu_ctr   <= alu_p0;
         a         <= rs_val_p0;
         b         <= b_p0;
         md        <= rt_val_p0;
         imm       <= ir[15:0];
         rd        <= rd_p0;
         npc       <= pc + XLEN'(4);
         jt        <= {pc[XLEN-1:28], ir[25:0], 2'b00};
      end else if (flush || advance) begin
         out_valid <= 1'b0;
         memtoreg  <= 1'b0;
         regwrite  <= 1'b0;
         memread   <= 1'b0;
         memwrite  <= 1'b0;
         branch    <= 1'b0;
         jump      <= 1'b0;
         illegal   <= 1'b0;
         alu_ctr   <= 3'd0;
      end
   end

   // Count cycles where a waiting instruction is blocked only by a load-use hazard
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (in_valid && hazard && advance && !flush) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule
